// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - hazard/stall control bundle between pipeline and sequencer
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [3:0]       id_rs1;
  logic [3:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic             id_halt;
  logic             idex_mem_to_reg;
  logic             idex_RegWrite;
  logic [3:0]       idex_reg_rd;
  logic             ex_redirect;
  logic             ex_ret;
  logic             mem_busy;
  logic             pc_stall;
  logic             ifid_stall;
  logic             ifid_flush;
  logic             idex_stall;
  logic             idex_bubble;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_halt,
           idex_mem_to_reg, idex_RegWrite, idex_reg_rd,
           ex_redirect, ex_ret, mem_busy,
    input  pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble,
           halted, stall_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_halt,
           idex_mem_to_reg, idex_RegWrite, idex_reg_rd,
           ex_redirect, ex_ret, mem_busy,
    output pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble,
           halted, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush/bubble sequencer for the 5-stage 16-bit core
module pipe_hazard_ctrl #(
  parameter int RET_BUBBLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  pipe_hazard_ctrl_if.slave hz
);
  typedef enum logic [1:0] {S_RUN, S_RET_DRAIN, S_HALT} state_t;

  state_t           state_q, state_d;
  logic [3:0]       drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble, halted;
  logic load_use;

  // r0 is hardwired zero, so an LW targeting it never creates a dependency
  assign load_use = hz.idex_mem_to_reg & hz.idex_RegWrite & (hz.idex_reg_rd != 4'd0) &
                    ((hz.id_use_rs1 & (hz.id_rs1 == hz.idex_reg_rd)) |
                     (hz.id_use_rs2 & (hz.id_rs2 == hz.idex_reg_rd)));

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_stall  = 1'b0;
    idex_bubble = 1'b0;
    halted      = 1'b0;

    case (state_q)
      S_RUN: begin
        if (hz.mem_busy) begin
          pc_stall   = 1'b1;
          ifid_stall = 1'b1;
          idex_stall = 1'b1;
        end else if (hz.ex_ret) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          drain_cnt_d = 4'(RET_BUBBLES);
          state_d     = S_RET_DRAIN;
        end else if (hz.ex_redirect) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end else if (hz.id_halt) begin
          pc_stall   = 1'b1;
          ifid_flush = 1'b1;
          state_d    = S_HALT;
        end else if (load_use) begin
          pc_stall    = 1'b1;
          ifid_stall  = 1'b1;
          idex_bubble = 1'b1;
        end
      end
      S_RET_DRAIN: begin
        if (hz.mem_busy) begin
          pc_stall   = 1'b1;
          ifid_stall = 1'b1;
          idex_stall = 1'b1;
        end else begin
          pc_stall    = 1'b1;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          drain_cnt_d = drain_cnt_q - 4'd1;
          if (drain_cnt_q == 4'd1) state_d = S_RUN;
        end
      end
      S_HALT: begin
        pc_stall   = 1'b1;
        ifid_flush = 1'b1;
        halted     = 1'b1;
      end
      default: state_d = S_RUN;
    endcase

    if (rst) begin
      pc_stall    = 1'b0;
      ifid_stall  = 1'b0;
      ifid_flush  = 1'b0;
      idex_stall  = 1'b0;
      idex_bubble = 1'b0;
      halted      = 1'b0;
    end

    stall_cnt_d = stall_cnt_q;
    if (pc_stall && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RUN;
      drain_cnt_q <= 4'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hz.pc_stall    = pc_stall;
  assign hz.ifid_stall  = ifid_stall;
  assign hz.ifid_flush  = ifid_flush;
  assign hz.idex_stall  = idex_stall;
  assign hz.idex_bubble = idex_bubble;
  assign hz.halted      = halted;
  assign hz.stall_cnt   = stall_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(16)) bus ();
  pipe_hazard_ctrl_if #(.CNT_W(4))  bus4 ();

  assign bus4.id_rs1          = bus.id_rs1;
  assign bus4.id_rs2          = bus.id_rs2;
  assign bus4.id_use_rs1      = bus.id_use_rs1;
  assign bus4.id_use_rs2      = bus.id_use_rs2;
  assign bus4.id_halt         = bus.id_halt;
  assign bus4.idex_mem_to_reg = bus.idex_mem_to_reg;
  assign bus4.idex_RegWrite   = bus.idex_RegWrite;
  assign bus4.idex_reg_rd     = bus.idex_reg_rd;
  assign bus4.ex_redirect     = bus.ex_redirect;
  assign bus4.ex_ret          = bus.ex_ret;
  assign bus4.mem_busy        = bus.mem_busy;

  pipe_hazard_ctrl #(.RET_BUBBLES(2), .CNT_W(16)) dut (.clk(clk), .rst(rst), .hz(bus.slave));
  pipe_hazard_ctrl #(.RET_BUBBLES(2), .CNT_W(4))  dut4 (.clk(clk), .rst(rst), .hz(bus4.slave));

  // {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble, halted}
  localparam logic [5:0] O_NONE = 6'b000000;
  localparam logic [5:0] O_LU   = 6'b110010;
  localparam logic [5:0] O_FB   = 6'b001010;
  localparam logic [5:0] O_DR   = 6'b101010;
  localparam logic [5:0] O_FRZ  = 6'b110100;
  localparam logic [5:0] O_HI   = 6'b101000;
  localparam logic [5:0] O_HT   = 6'b101001;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_in();
    bus.id_rs1 = 4'd0; bus.id_rs2 = 4'd0;
    bus.id_use_rs1 = 1'b0; bus.id_use_rs2 = 1'b0;
    bus.id_halt = 1'b0;
    bus.idex_mem_to_reg = 1'b0; bus.idex_RegWrite = 1'b0; bus.idex_reg_rd = 4'd0;
    bus.ex_redirect = 1'b0; bus.ex_ret = 1'b0; bus.mem_busy = 1'b0;
  endtask

  task automatic set_idex(input logic lw, input logic wr, input logic [3:0] rd);
    bus.idex_mem_to_reg = lw; bus.idex_RegWrite = wr; bus.idex_reg_rd = rd;
  endtask

  task automatic set_id(input logic u1, input logic [3:0] r1, input logic u2, input logic [3:0] r2);
    bus.id_use_rs1 = u1; bus.id_rs1 = r1; bus.id_use_rs2 = u2; bus.id_rs2 = r2;
  endtask

  // Checks one cycle with the inputs already applied, then advances past the edge.
  task automatic cyc(input string tag, input logic [5:0] e);
    int exp4;
    #1;
    exp4 = (exp_cnt > 15) ? 15 : exp_cnt;
    check(tag, {26'd0, bus.pc_stall, bus.ifid_stall, bus.ifid_flush, bus.idex_stall,
                bus.idex_bubble, bus.halted}, {26'd0, e});
    check({tag, "_w4"}, {26'd0, bus4.pc_stall, bus4.ifid_stall, bus4.ifid_flush, bus4.idex_stall,
                         bus4.idex_bubble, bus4.halted}, {26'd0, e});
    check({tag, "_cnt"}, {16'd0, bus.stall_cnt}, exp_cnt);
    check({tag, "_cnt4"}, {28'd0, bus4.stall_cnt}, exp4);
    @(posedge clk);
    if (rst) exp_cnt = 0;
    else if (e[5] && exp_cnt < 65535) exp_cnt++;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    clear_in();
    bus.ex_ret = 1'b1; bus.ex_redirect = 1'b1; bus.id_halt = 1'b1; bus.mem_busy = 1'b1;
    @(posedge clk); #1;
    cyc("rst_gate", O_NONE);
    rst = 1'b0;
    clear_in();
    cyc("idle", O_NONE);

    // load-use on rs1, then LW moves on
    set_idex(1, 1, 4'd3); set_id(1, 4'd3, 0, 4'd0);
    cyc("lu_rs1", O_LU);
    set_idex(0, 1, 4'd3); set_id(1, 4'd3, 0, 4'd0);
    cyc("lu_clear", O_NONE);
    set_idex(1, 1, 4'd0); set_id(1, 4'd0, 1, 4'd0);
    cyc("lu_r0", O_NONE);
    set_idex(1, 0, 4'd5); set_id(1, 4'd5, 0, 4'd0);
    cyc("lu_nowr", O_NONE);
    set_idex(0, 1, 4'd5); set_id(1, 4'd5, 1, 4'd5);
    cyc("lu_add", O_NONE);
    set_idex(1, 1, 4'd7); set_id(1, 4'd2, 1, 4'd7);
    cyc("lu_rs2", O_LU);
    set_idex(1, 1, 4'd7); set_id(1, 4'd2, 0, 4'd7);
    cyc("lu_rs2_unused", O_NONE);
    clear_in();

    // ret drain
    bus.ex_ret = 1'b1;
    cyc("ret_c1", O_FB);
    bus.ex_ret = 1'b0; bus.ex_redirect = 1'b1; bus.id_halt = 1'b1;
    cyc("ret_c2", O_DR);
    cyc("ret_c3", O_DR);
    clear_in();
    cyc("ret_done", O_NONE);

    // mem_busy freezes a coincident redirect
    bus.ex_redirect = 1'b1; bus.mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) cyc("busy_redir", O_FRZ);
    bus.mem_busy = 1'b0;
    cyc("redir_after_busy", O_FB);
    clear_in();
    cyc("redir_done", O_NONE);

    // ret with redirect together, mem_busy holding the drain count
    bus.ex_ret = 1'b1; bus.ex_redirect = 1'b1;
    cyc("retredir_c1", O_FB);
    clear_in();
    bus.mem_busy = 1'b1;
    cyc("drain_busy", O_FRZ);
    bus.mem_busy = 1'b0;
    cyc("drain_b1", O_DR);
    cyc("drain_b2", O_DR);
    cyc("drain_done", O_NONE);

    // reset in the middle of a ret drain
    bus.ex_ret = 1'b1;
    cyc("rstdrain_c1", O_FB);
    clear_in();
    rst = 1'b1;
    cyc("rstdrain_gate", O_NONE);
    rst = 1'b0;
    cyc("rstdrain_run", O_NONE);
    bus.ex_redirect = 1'b1;
    cyc("rstdrain_redir", O_FB);
    clear_in();

    // halt parks the core
    bus.id_halt = 1'b1;
    cyc("halt_enter", O_HI);
    bus.id_halt = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (i == 50) begin
        bus.ex_ret = 1'b1;
        set_idex(1, 1, 4'd4); set_id(1, 4'd4, 0, 4'd0);
      end
      cyc("halted", O_HT);
    end
    clear_in();
    rst = 1'b1;
    cyc("halt_rst", O_NONE);
    rst = 1'b0;
    cyc("after_halt_rst", O_NONE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
